// File: rtl/demux_reg_16_4.sv
`default_nettype none
// ============================================================================
// Module  : demux_reg_16_4
// Brief   : 1:4 registered demultiplexer with one-entry valid/ready output slots
// Revision: 1.0  initial release
// ============================================================================
module demux_reg_16_4 #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] D,
    input  logic             S0,
    input  logic             S1,
    input  logic             IN_VLD,
    output logic             IN_RDY,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic             V0,
    output logic             V1,
    output logic             V2,
    output logic             V3,
    input  logic             R0,
    input  logic             R1,
    input  logic             R2,
    input  logic             R3,
    output logic             BUSY,
    output logic [7:0]       CNT
);

    logic [1:0]       sel;
    logic [3:0]       sink_rdy;
    logic [3:0]       valid;
    logic [3:0]       valid_next;
    logic [3:0]       wr_en;
    logic             accept;
    logic             busy;
    logic [7:0]       count;
    logic [WIDTH-1:0] slot_data [4];

    assign sel      = {S1, S0};
    assign sink_rdy = {R3, R2, R1, R0};

    // A full slot can still accept when its sink drains in the same cycle.
    assign IN_RDY = ~valid[sel] | sink_rdy[sel];
    assign accept = IN_VLD & IN_RDY;

    always_comb begin
        wr_en = 4'b0000;
        if (accept) begin
            wr_en[sel] = 1'b1;
        end
        valid_next = (valid & ~sink_rdy) | wr_en;
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_slot
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    slot_data[i] <= '0;
                end else if (wr_en[i]) begin
                    slot_data[i] <= D;
                end
            end
        end
    endgenerate

    // BUSY is its own flop so the output carries no combinational path.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            valid <= 4'b0000;
            busy  <= 1'b0;
            count <= 8'd0;
        end else begin
            valid <= valid_next;
            busy  <= |valid_next;
            if (accept) begin
                count <= count + 8'd1;
            end
        end
    end

    assign Y0   = slot_data[0];
    assign Y1   = slot_data[1];
    assign Y2   = slot_data[2];
    assign Y3   = slot_data[3];
    assign V0   = valid[0];
    assign V1   = valid[1];
    assign V2   = valid[2];
    assign V3   = valid[3];
    assign BUSY = busy;
    assign CNT  = count;

endmodule
`default_nettype wire
